// File: rtl/neokeon_pkg.sv
// ------------------------------------------------------------------
// neokeon_pkg -- round constants, FSM encoding, Noekeon step functions
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package neokeon_pkg;

  localparam logic [7:0]  RC_INIT        = 8'h80;
  localparam logic [7:0]  RC_FINAL       = 8'hD4;
  localparam logic [7:0]  RC_POLY        = 8'h1B;
  localparam int unsigned NUM_ROUNDS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } core_state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round-constant LFSR: doubling in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] rc_step(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
  endfunction

  // Words are big-endian: a0 = bits[127:96], a3 = bits[31:0]
  function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = a0 ^ a2;
    t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {s[127:96], rotl32(s[95:64], 31), rotl32(s[63:32], 27), rotl32(s[31:0], 30)};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

endpackage

`default_nettype wire

// File: rtl/neokeon_last_round.sv
// ------------------------------------------------------------------
// neokeon_last_round -- output step: constant1, Theta, constant2 (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module neokeon_last_round
  import neokeon_pkg::*;
(
  input  logic [127:0] key,
  input  logic [127:0] state,
  input  logic [31:0]  constant1,
  input  logic [31:0]  constant2,
  output logic [127:0] next_state
);

  assign next_state = theta(key, state ^ {constant1, 96'b0}) ^ {constant2, 96'b0};

endmodule

`default_nettype wire

// File: rtl/neokeon_round.sv
// ------------------------------------------------------------------
// neokeon_round -- one full combinational Noekeon round (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module neokeon_round
  import neokeon_pkg::*;
(
  input  logic [127:0] key,
  input  logic [127:0] state,
  input  logic [7:0]   rc,
  output logic [127:0] next_state
);

  logic [127:0] after_theta;

  assign after_theta = theta(key, state ^ {24'b0, rc, 96'b0});
  assign next_state  = pi2(gamma(pi1(after_theta)));

endmodule

`default_nettype wire

// File: rtl/neokeon_iter_core.sv
// ------------------------------------------------------------------
// neokeon_iter_core -- iterative Noekeon encryption, one round per cycle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module neokeon_iter_core
  import neokeon_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         inClk,
  input  logic         inRstn,
  input  logic         inStart,
  input  logic [127:0] inDataKey,
  input  logic [127:0] inDataState,
  output logic         outBusy,
  output logic         outDone,
  output logic [127:0] outDataState
);

  localparam int unsigned CNT_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  core_state_t      state, state_next;
  logic [127:0]     key_reg, data_reg, result_reg;
  logic [127:0]     round_out, final_out;
  logic [7:0]       rc;
  logic [CNT_W-1:0] round_cnt;
  logic             last_round;

  assign last_round   = (round_cnt == CNT_W'(NUM_ROUNDS - 1));
  assign outDataState = result_reg;

  neokeon_round u_round (
    .key        (key_reg),
    .state      (data_reg),
    .rc         (rc),
    .next_state (round_out)
  );

  // After the last round rc has advanced to the output-step constant
  neokeon_last_round u_last_round (
    .key        (key_reg),
    .state      (data_reg),
    .constant1  ({24'b0, rc}),
    .constant2  (32'b0),
    .next_state (final_out)
  );

  always_ff @(posedge inClk or negedge inRstn) begin
    if (!inRstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    outBusy    = 1'b0;
    outDone    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inStart) state_next = ST_ROUND;
      end
      ST_ROUND: begin
        outBusy = 1'b1;
        if (last_round) state_next = ST_FINAL;
      end
      ST_FINAL: begin
        outBusy    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        outDone    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstn) begin
    if (!inRstn) begin
      key_reg    <= '0;
      data_reg   <= '0;
      result_reg <= '0;
      rc         <= '0;
      round_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inStart) begin
            key_reg   <= inDataKey;
            data_reg  <= inDataState;
            rc        <= RC_INIT;
            round_cnt <= '0;
          end
        end
        ST_ROUND: begin
          data_reg  <= round_out;
          rc        <= rc_step(rc);
          round_cnt <= round_cnt + CNT_W'(1);
        end
        ST_FINAL: result_reg <= final_out;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neokeon_iter_core.sv
// ------------------------------------------------------------------
// tb_neokeon_iter_core -- directed + random bench with a Noekeon model
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_neokeon_iter_core;

  typedef logic [0:3][31:0] blk_t;

  localparam logic [127:0] CT_ZERO = 128'hb1656851699e29fa24b70148503d2dfc;
  localparam logic [127:0] CT_ONES = 128'h2a78421b87c7d0924f26113f1d1349b2;
  localparam logic [127:0] CT_CHN  = 128'he2f687e07b75660ffc372233bc47532c;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] pt = '0;
  logic         busy, done;
  logic [127:0] ct;

  int total = 0;
  int bad   = 0;

  neokeon_iter_core #(.NUM_ROUNDS(16)) dut (
    .inClk        (clk),
    .inRstn       (rstn),
    .inStart      (start),
    .inDataKey    (key),
    .inDataState  (pt),
    .outBusy      (busy),
    .outDone      (done),
    .outDataState (ct)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic blk_t ref_theta(input blk_t k, input blk_t a);
    blk_t r;
    logic [31:0] t;
    r = a;
    t = r[0] ^ r[2];
    t = t ^ rol(t, 8) ^ rol(t, 24);
    r[1] = r[1] ^ t;
    r[3] = r[3] ^ t;
    r = r ^ k;
    t = r[1] ^ r[3];
    t = t ^ rol(t, 8) ^ rol(t, 24);
    r[0] = r[0] ^ t;
    r[2] = r[2] ^ t;
    return r;
  endfunction

  function automatic blk_t ref_pi(input blk_t a, input bit fwd);
    blk_t r;
    int sh;
    r = a;
    for (int w = 1; w < 4; w++) begin
      sh = (w == 1) ? 1 : (w == 2) ? 5 : 2;
      r[w] = rol(a[w], fwd ? sh : 32 - sh);
    end
    return r;
  endfunction

  // Gamma as the Noekeon 4-bit S-box applied to each bit column (a3,a2,a1,a0)
  function automatic blk_t ref_gamma(input blk_t a);
    blk_t r;
    logic [63:0] sb;
    logic [3:0] nib, v;
    int idx;
    sb = 64'h7A2C48F0591E3DB6;
    r  = '0;
    for (int b = 0; b < 32; b++) begin
      nib = {a[3][b], a[2][b], a[1][b], a[0][b]};
      idx = int'(nib);
      v = sb[63 - 4*idx -: 4];
      r[0][b] = v[0];
      r[1][b] = v[1];
      r[2][b] = v[2];
      r[3][b] = v[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k_in, input logic [127:0] p_in);
    blk_t k, a;
    int rcv;
    k = k_in;
    a = p_in;
    rcv = 'h80;
    for (int r = 0; r < 16; r++) begin
      a[0] = a[0] ^ 32'(rcv);
      a = ref_theta(k, a);
      a = ref_pi(a, 1'b1);
      a = ref_gamma(a);
      a = ref_pi(a, 1'b0);
      rcv = rcv * 2;
      if (rcv > 255) rcv = rcv ^ 'h11B;
    end
    a[0] = a[0] ^ 32'(rcv);
    a = ref_theta(k, a);
    return a;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One encryption; optional extra start pulse (with new inputs) at cycle pulse_at
  task automatic run(input string tag, input logic [127:0] k, input logic [127:0] p,
                     input int pulse_at, input logic [127:0] exp);
    int lat, ndone;
    logic [127:0] res;
    lat = -1; ndone = 0; res = '0;
    key = k; pt = p; start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, "_busy_first"}, 128'(busy), 128'd1);
      end
      if (cyc == pulse_at) begin
        start = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
      end else if (cyc == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          res = ct;
          check({tag, "_busy_in_done"}, 128'(busy), 128'd0);
        end
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'd18);
    check({tag, "_ndone"}, 128'(ndone), 128'd1);
    check({tag, "_result"}, res, exp);
    check({tag, "_held"}, ct, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]   rc_exp [17];
  logic [7:0]   rcs[$];
  int           done_cyc[$];
  int           gap, nd, v;
  logic [127:0] rk, rp;

  initial begin
    v = 'h80;
    for (int i = 0; i < 17; i++) begin
      rc_exp[i] = 8'(v);
      v = v * 2;
      if (v > 255) v = v ^ 'h11B;
    end

    // reset state
    #12;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_ct", ct, 128'd0);
    rstn = 1'b1;
    tick();

    // known-answer vectors
    run("kat_zero", '0, '0, -1, CT_ZERO);
    run("kat_ones", '1, '1, -1, CT_ONES);
    run("kat_chain", CT_ZERO, CT_ONES, -1, CT_CHN);

    // start pulse while busy must be ignored
    run("busy_start", '0, '0, 5, CT_ZERO);

    // reset in mid-run
    nd = 0;
    key = '0; pt = '0; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (done) nd++;
    end
    rstn = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_ct", ct, 128'd0);
    check("midrst_rc", 128'(dut.rc), 128'd0);
    repeat (3) begin
      tick();
      if (done) nd++;
    end
    check("midrst_no_done", 128'(nd), 128'd0);
    rstn = 1'b1;
    tick();
    run("post_rst", '0, '0, -1, CT_ZERO);

    // start held high for three back-to-back runs
    gap = 0;
    key = '0; pt = '0; start = 1'b1;
    for (int c = 1; c <= 100 && done_cyc.size() < 3; c++) begin
      tick();
      if (busy) rcs.push_back(dut.rc);
      if (done) begin
        done_cyc.push_back(c);
        check("held_result", ct, CT_ZERO);
        if (done_cyc.size() == 3) start = 1'b0;
      end else if (!busy && done_cyc.size() > 0) begin
        gap++;
      end
    end
    start = 1'b0;
    check("held_ndone", 128'(done_cyc.size()), 128'd3);
    if (done_cyc.size() == 3) begin
      check("held_period1", 128'(done_cyc[1] - done_cyc[0]), 128'd19);
      check("held_period2", 128'(done_cyc[2] - done_cyc[1]), 128'd19);
    end
    check("held_idle_gaps", 128'(gap), 128'd2);
    check("held_rc_count", 128'(rcs.size()), 128'd51);
    for (int i = 0; i < rcs.size() && i < 51; i++)
      check($sformatf("held_rc%0d", i), 128'(rcs[i]), 128'(rc_exp[i % 17]));
    repeat (3) tick();

    // random vectors against the model
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run($sformatf("rand%0d", n), rk, rp, -1, ref_encrypt(rk, rp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
